uart_tx: RTL
============

// Module: uart_tx
//
// PURPOSE
// - Serial UART transmitter, 8N1 by default with optional parity and 2 stop bits. Counterpart of the team's UART receiver.
// - Takes parallel bytes over a valid/ready handshake and drives the idle-high serial line.
// - A one-deep holding register lets frames run back-to-back with no idle gap.
// - Sits between a host/CPU-side producer and the board TX pin.
//
// PARAMETERS
// - DATA_WIDTH    8     payload bits per frame, sent LSB first
// - CLKS_PER_BIT  5208  clocks per bit (50 MHz / 9600); must be >= 2
// - PARITY_EN     0     1: insert a parity bit after the data bits
// - PARITY_ODD    0     0: even parity, 1: odd parity (ignored if PARITY_EN=0)
// - STOP_BITS     1     number of stop bits, 1 or 2
//
// PORTS
// - clk        in   1           single clock, rising edge
// - rst        in   1           asynchronous, active-high reset
// - tx_valid   in   1           producer offers data_in
// - data_in    in   DATA_WIDTH  byte to send; sampled when tx_valid && tx_ready
// - tx_ready   out  1           holding register empty; can accept a byte
// - tx_busy    out  1           frame in progress (state != IDLE)
// - tx_done    out  1           one-cycle pulse when a frame's last stop bit completes
// - tx_serial  out  1           serial line, idle high
//
// BEHAVIOUR
// - Reset (async, immediate): tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0. FSM goes to IDLE, counters clear, holding register is invalidated.
//   - Reset mid-frame aborts the frame. The line returns high in the same instant; no partial frame resumes.
// - Handshake:
//   - A byte transfers on a rising edge with tx_valid && tx_ready.
//   - data_in is copied into the holding register, and hold_full is set.
//   - tx_ready = !hold_full (registered).
//   - tx_valid while tx_ready=0 is ignored; the producer must hold it.
// - FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
//   - IDLE: tx_serial=1. If hold_full, load the shift register from hold, clear hold_full, and go to START.
//     - An accept at edge N gives tx_serial=0 from edge N+2.
//   - START: line 0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//   - DATA: line = shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
//     - After bit DATA_WIDTH-1: go to PARITY if PARITY_EN, else STOP.
//   - PARITY: line = ^payload ^ PARITY_ODD for CLKS_PER_BIT cycles, then STOP.
//   - STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, tx_done=1 for exactly one cycle. Then:
//     - hold_full: reload and go straight to START (no idle bit).
//     - else: go to IDLE.
// - Frame length = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, exact, no jitter.
// - The holding register may be refilled at any time a frame is in progress. An accept on the same edge the frame ends still chains with no gap.
// - Payload parity is computed when the shift register loads, not from the live shift register.
// - Counters:
//   - clk_cnt width is $clog2(STOP_BITS*CLKS_PER_BIT). It wraps to 0 at terminal count and never overflows.
//   - bit_idx width is $clog2(DATA_WIDTH)+1.
// - Invalid state encodings recover to IDLE with the line high.
//
// STRUCTURE
// - Shared package uart_pkg: FSM state encodings (shared with the receiver), default CLKS_PER_BIT, and the parity helper function.
// - One sub-module: uart_baud_cnt. It is a loadable down-counter emitting a bit_end strobe and is reusable by the receiver.
// - This module holds the FSM, holding register, shift register and parity.
//
// TESTING (CLKS_PER_BIT=4 unless noted)
// - 8N1, send 0xA5 from idle:
//   - line = 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 4 cycles; 40 cycles total.
//   - tx_done pulses once on cycle 40. tx_busy is high for 40 cycles.
// - Back-to-back:
//   - offer 0x00 then 0xFF immediately. The second accept occurs while the first frame runs, and tx_ready drops.
//   - The second start bit immediately follows the first stop bit; 80 cycles with no idle gap. tx_done pulses twice.
// - Backpressure:
//   - with hold full, hold tx_valid with 0x3C for 20 cycles. No extra frame is sent and data is not corrupted.
//   - The byte is accepted exactly when tx_ready rises.
// - PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07:
//   - parity bit = 1, then two stop bits; frame = 48 cycles.
//   - Repeat with PARITY_ODD=1: parity bit = 0.
// - Reset mid-frame:
//   - assert rst during DATA bit 3. tx_serial=1 the same instant, tx_ready=1, tx_busy=0, no tx_done pulse.
//   - After release, a new 0x55 frame transmits cleanly.
// - CLKS_PER_BIT=5208: a single 0x41 frame measures 52080 cycles from start edge to tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and the
// parity helper, common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 50 MHz clock, 9600 baud
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 5208;

  // Widest payload the parity helper accepts; narrower payloads are
  // zero-extended, which leaves the XOR reduction unchanged.
  localparam int unsigned UART_PARITY_MAX_W = 64;

  // Parity bit for a payload: even parity when odd=0, odd parity when odd=1.
  function automatic logic uart_parity(input logic [UART_PARITY_MAX_W-1:0] data,
                                       input logic                         odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter that times one bit period (or a stretch of bit
// periods). bit_end is high while the count sits at zero.
module uart_baud_cnt #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             bit_end
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input with a one-deep holding register,
// shift-register framing (start, data LSB first, optional parity, 1 or 2
// stop bits) and registered serial/status outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_serial
);

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             ODD_SEL   = (PARITY_ODD != 0);

  uart_state_e           state_q,     state_d;
  logic [DATA_WIDTH-1:0] hold_q,      hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic                  parity_q,    parity_d;
  logic [IDX_W-1:0]      bit_idx_q,   bit_idx_d;
  logic                  tx_serial_q, tx_serial_d;
  logic                  tx_ready_q,  tx_ready_d;
  logic                  tx_busy_q,   tx_busy_d;
  logic                  tx_done_q,   tx_done_d;

  logic                  accept;
  logic                  do_load;
  logic [DATA_WIDTH-1:0] load_src;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_val;
  logic                  bit_end;

  assign accept = tx_valid && tx_ready_q;

  uart_baud_cnt #(
    .WIDTH (CNT_W)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .bit_end  (bit_end)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    do_load     = 1'b0;
    load_src    = hold_q;
    cnt_load    = 1'b0;
    cnt_val     = BIT_LOAD;

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          do_load     = 1'b1;
          hold_full_d = 1'b0;
          cnt_load    = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          cnt_load  = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d  = shift_q >> 1;
          cnt_load = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
            end else begin
              cnt_val = STOP_LOAD;
              state_d = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          cnt_val  = STOP_LOAD;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (hold_full_q) begin
            do_load     = 1'b1;
            hold_full_d = 1'b0;
            cnt_load    = 1'b1;
            state_d     = ST_START;
          end else if (accept) begin
            // A byte accepted on the frame's last edge goes straight into the
            // shift register so the next start bit follows with no gap.
            do_load     = 1'b1;
            load_src    = data_in;
            hold_full_d = 1'b0;
            cnt_load    = 1'b1;
            state_d     = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_load) begin
      shift_d  = load_src;
      parity_d = uart_parity(UART_PARITY_MAX_W'(load_src), ODD_SEL);
    end

    // Outputs follow the current state one clock later, so an accept at
    // edge N drives the start bit from edge N+2.
    unique case (state_q)
      ST_START:  tx_serial_d = 1'b0;
      ST_DATA:   tx_serial_d = shift_q[0];
      ST_PARITY: tx_serial_d = parity_q;
      default:   tx_serial_d = 1'b1;
    endcase
    tx_busy_d  = (state_q == ST_START) || (state_q == ST_DATA) ||
                 (state_q == ST_PARITY) || (state_q == ST_STOP);
    tx_done_d  = (state_q == ST_STOP) && bit_end;
    tx_ready_d = !hold_full_d;
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      tx_serial_q <= tx_serial_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule
